fc_port_sm: RTL and testbench

Fibre Channel port state machine and TX scheduler for one 8G link. It decodes received primitive sequences and sequences the port through link initialization, recovery and failure states (FC-FS-5 subset). It owns the transceiver TX stream: it emits the primitive sequence for the current state, or, when Active, frames from the upstream frame source with IDLE fill between them. It sits between the frame path and the transceiver, in the TX clock domain; RX words reach it through an upstream CDC FIFO.

---
 rtl/fc_pkg.sv | 47 ++++
 rtl/fc_prim_match.sv | 43 ++++
 rtl/fc_port_sm.sv | 128 ++++++++++++
 tb/tb_fc_port_sm.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Fibre Channel shared definitions: ordered-set constants, port states and
// primitive classification used by the port state machine.
package fc;

    localparam logic [3:0]  OS_K  = 4'b1000;
    localparam logic [31:0] NOS   = 32'hBC55BF45;
    localparam logic [31:0] OLS   = 32'hBC358A55;
    localparam logic [31:0] LR    = 32'hBC49BF49;
    localparam logic [31:0] LRR   = 32'hBC35BF49;
    localparam logic [31:0] IDLE  = 32'hBC95B5B5;
    localparam logic [31:0] R_RDY = 32'hBC954A4A;

    typedef enum logic [2:0] {
        LF2 = 3'd0, LF1, OL1, OL2, LR2, LR3, AC
    } port_state_t;

    typedef enum logic [2:0] {
        PRIM_NONE = 3'd0, PRIM_NOS, PRIM_OLS, PRIM_LR, PRIM_LRR, PRIM_IDLE, PRIM_R_RDY
    } prim_t;

    localparam int PRIM_N = 7;

    function automatic prim_t map_primitive(input logic [35:0] w);
        if (w[35:32] != OS_K) return PRIM_NONE;
        case (w[31:0])
            NOS:     return PRIM_NOS;
            OLS:     return PRIM_OLS;
            LR:      return PRIM_LR;
            LRR:     return PRIM_LRR;
            IDLE:    return PRIM_IDLE;
            R_RDY:   return PRIM_R_RDY;
            default: return PRIM_NONE;
        endcase
    endfunction

    // Primitive sequence a port transmits while sitting in a given state.
    function automatic logic [31:0] state_prim(input port_state_t s);
        case (s)
            LF2:      return NOS;
            LF1, OL1: return OLS;
            OL2:      return LR;
            LR2:      return LRR;
            default:  return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/fc_prim_match.sv
// Primitive sequence recognizer: counts consecutive identical ordered sets and
// flags a sequence once PRIM_MATCH of them arrive in a row.
module fc_prim_match import fc::*; #(
    parameter int PRIM_MATCH = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [35:0]       rx_data,
    input  logic              rx_valid,
    output logic [PRIM_N-1:0] seq_rcvd,
    output logic              idle_rcvd
);

    localparam int CW = $clog2(PRIM_MATCH + 1);

    prim_t         prim, last_prim;
    logic [CW-1:0] cnt, cnt_nxt;

    // Recognition is combinational on the current word so the FSM can act on
    // it at the very next edge.
    always_comb begin
        prim     = rx_valid ? map_primitive(rx_data) : PRIM_NONE;
        cnt_nxt  = '0;
        if (prim != PRIM_NONE)
            cnt_nxt = (prim != last_prim) ? CW'(1) :
                      (cnt == CW'(PRIM_MATCH)) ? cnt : cnt + 1'b1;
        seq_rcvd = '0;
        if (cnt_nxt == CW'(PRIM_MATCH))
            seq_rcvd[prim] = 1'b1;
        idle_rcvd = (prim == PRIM_IDLE) || (prim == PRIM_R_RDY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_prim <= PRIM_NONE;
            cnt       <= '0;
        end else begin
            last_prim <= prim;
            cnt       <= cnt_nxt;
        end
    end

endmodule

// File: rtl/fc_port_sm.sv
// Fibre Channel port state machine and TX scheduler: link init/recovery FSM
// driving primitive sequences, or frames with IDLE fill once Active.
module fc_port_sm import fc::*; #(
    parameter int PRIM_MATCH     = 3,
    parameter int TIMEOUT_CYCLES = 21_250_000,
    parameter int LOS_CYCLES     = 21_250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [35:0] rx_data,
    input  logic        rx_valid,
    input  logic [35:0] frm_data,
    input  logic        frm_valid,
    input  logic        frm_sop,
    input  logic        frm_eop,
    output logic        frm_ready,
    output logic [35:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output port_state_t state,
    output logic        link_up,
    output logic [15:0] link_fail_cnt,
    output logic [15:0] frm_drop_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOS_CYCLES + 1);

    logic [PRIM_N-1:0] seq;
    logic              idle_rcvd;
    port_state_t       nxt;
    logic [TW-1:0]     timer;
    logic [LW-1:0]     los_cnt;
    logic              mid_frame, draining;
    logic              timed, los, tmo, fwd, drop_evt, start_drain;

    fc_prim_match #(.PRIM_MATCH(PRIM_MATCH)) u_match (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .seq_rcvd (seq),
        .idle_rcvd(idle_rcvd)
    );

    assign frm_ready = (state == AC && tx_ready && (mid_frame || frm_sop)) || draining;
    assign fwd       = state == AC && tx_ready && !draining && frm_valid && (mid_frame || frm_sop);

    always_comb begin
        timed = state inside {OL1, OL2, LR2, LR3, LF1};
        los   = !rx_valid && los_cnt == LW'(LOS_CYCLES - 1) && state != LF2;
        tmo   = timed && timer == TW'(TIMEOUT_CYCLES - 1);
        nxt   = state;
        if (los || tmo) nxt = LF2;
        else case (state)
            LF2: if (seq[PRIM_NOS]) nxt = LF1; else if (seq[PRIM_OLS]) nxt = OL2;
            LF1: if (seq[PRIM_OLS]) nxt = OL2; else if (seq[PRIM_LR]) nxt = LR2;
            OL1: if (seq[PRIM_OLS]) nxt = OL2; else if (seq[PRIM_LR]) nxt = LR2;
                 else if (seq[PRIM_NOS]) nxt = LF1;
            OL2: if (seq[PRIM_LR]) nxt = LR2; else if (seq[PRIM_LRR]) nxt = LR3;
                 else if (seq[PRIM_NOS]) nxt = LF1;
            LR2: if (seq[PRIM_LRR]) nxt = LR3; else if (idle_rcvd) nxt = AC;
                 else if (seq[PRIM_NOS]) nxt = LF1;
            LR3: if (idle_rcvd) nxt = AC; else if (seq[PRIM_LR]) nxt = LR2;
                 else if (seq[PRIM_NOS]) nxt = LF1;
            AC:  if (seq[PRIM_LR]) nxt = LR2; else if (seq[PRIM_OLS]) nxt = OL2;
                 else if (seq[PRIM_NOS]) nxt = LF1;
            default: nxt = LF2;
        endcase

        // A frame cut short (link drop, source underrun, or a stray non-SOF
        // word at a boundary) is counted once and its remainder drained.
        drop_evt    = 1'b0;
        start_drain = 1'b0;
        if (state == AC && nxt != AC) begin
            if (mid_frame || fwd) begin
                drop_evt    = 1'b1;
                start_drain = !(fwd && frm_eop);
            end
        end else if (state == AC && tx_ready && !draining) begin
            if ((mid_frame && !frm_valid) || (!mid_frame && frm_valid && !frm_sop)) begin
                drop_evt    = 1'b1;
                start_drain = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= LF2;
            link_up       <= 1'b0;
            tx_valid      <= 1'b0;
            tx_data       <= {OS_K, NOS};
            link_fail_cnt <= '0;
            frm_drop_cnt  <= '0;
            timer         <= '0;
            los_cnt       <= '0;
            mid_frame     <= 1'b0;
            draining      <= 1'b0;
        end else begin
            state    <= nxt;
            link_up  <= nxt == AC;
            tx_valid <= 1'b1;
            timer    <= (nxt != state || !timed) ? '0 : timer + 1'b1;
            los_cnt  <= rx_valid ? '0 :
                        (los_cnt == LW'(LOS_CYCLES - 1)) ? los_cnt : los_cnt + 1'b1;
            if (nxt != state && (nxt == LF1 || nxt == LF2) && link_fail_cnt != 16'hFFFF)
                link_fail_cnt <= link_fail_cnt + 1'b1;
            if (drop_evt && frm_drop_cnt != 16'hFFFF)
                frm_drop_cnt <= frm_drop_cnt + 1'b1;
            if (start_drain)
                draining <= 1'b1;
            else if (draining && frm_valid && frm_eop)
                draining <= 1'b0;
            if (nxt != AC || drop_evt)
                mid_frame <= 1'b0;
            else if (fwd)
                mid_frame <= !frm_eop;
            // tx_data holds until the transceiver takes it
            if (tx_ready || !tx_valid) begin
                if (nxt != AC)  tx_data <= {OS_K, state_prim(nxt)};
                else if (fwd)   tx_data <= frm_data;
                else            tx_data <= {OS_K, IDLE};
            end
        end
    end

endmodule

// File: tb/tb_fc_port_sm.sv
// Directed bench for fc_port_sm: link bring-up, frame forwarding with TX
// backpressure, mid-frame link loss, near-miss sequences, LOS and timeout.
module tb_fc_port_sm;

    localparam int TMO = 60;
    localparam int LOS = 20;

    localparam logic [35:0] W_NOS  = 36'h8BC55BF45;
    localparam logic [35:0] W_OLS  = 36'h8BC358A55;
    localparam logic [35:0] W_LR   = 36'h8BC49BF49;
    localparam logic [35:0] W_LRR  = 36'h8BC35BF49;
    localparam logic [35:0] W_IDLE = 36'h8BC95B5B5;
    localparam logic [35:0] W_DATA = 36'h012345678;

    localparam logic [2:0] S_LF2 = 3'd0, S_LF1 = 3'd1, S_OL2 = 3'd3,
                           S_LR2 = 3'd4, S_LR3 = 3'd5, S_AC = 3'd6;

    logic        clk = 1'b0, reset = 1'b1;
    logic [35:0] rx_data = '0, frm_data = '0, tx_data;
    logic        rx_valid = 1'b1, frm_valid = 1'b0, frm_sop = 1'b0, frm_eop = 1'b0;
    logic        frm_ready, tx_valid, tx_ready = 1'b1, link_up;
    logic [2:0]  state;
    logic [15:0] link_fail_cnt, frm_drop_cnt;

    int n_cmp = 0, n_err = 0;
    logic mon_en = 1'b0;
    logic [35:0] txq[$];
    logic [35:0] frame[8];

    always #5 clk = ~clk;

    fc_port_sm #(.PRIM_MATCH(3), .TIMEOUT_CYCLES(TMO), .LOS_CYCLES(LOS)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .frm_data(frm_data), .frm_valid(frm_valid), .frm_sop(frm_sop), .frm_eop(frm_eop),
        .frm_ready(frm_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .state(state), .link_up(link_up), .link_fail_cnt(link_fail_cnt),
        .frm_drop_cnt(frm_drop_cnt)
    );

    always @(negedge clk)
        if (mon_en && tx_valid && tx_ready) txq.push_back(tx_data);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rx_word(input logic v, input logic [35:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk); #1;
    endtask

    task automatic push_frame(input int n, input int gap_at);
        logic acc;
        for (int i = 0; i < n; i++) begin
            frm_data  = frame[i];
            frm_valid = 1'b1;
            frm_sop   = (i == 0);
            frm_eop   = (i == n - 1);
            if (i == gap_at) begin
                tx_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 tx_ready = 1'b1;
            end
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                @(negedge clk); acc = frm_ready;
                @(posedge clk); #1;
            end
            chk($sformatf("frm_accept_%0d", i), 64'(acc), 64'd1);
        end
        frm_valid = 1'b0; frm_sop = 1'b0; frm_eop = 1'b0;
    endtask

    initial begin
        int f, idx, cyc;
        logic acc;

        frame[0] = 36'h8BCB5E6E6;
        for (int i = 1; i < 7; i++) frame[i] = 36'h0D0000000 + 36'(i);
        frame[7] = 36'h8BC95D5D5;

        // reset state
        repeat (3) @(posedge clk); #1;
        chk("rst_state", 64'(state), 64'(S_LF2));
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'(W_NOS));
        chk("rst_link_up", 64'(link_up), 64'd0);
        chk("rst_frm_ready", 64'(frm_ready), 64'd0);
        chk("rst_cnts", {32'd0, link_fail_cnt, frm_drop_cnt}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_tx_valid", 64'(tx_valid), 64'd1);
        chk("post_rst_tx_data", 64'(tx_data), 64'(W_NOS));

        // LF2 -> LF1 -> OL2 -> LR3 -> AC
        rx_word(1, W_NOS); rx_word(1, W_NOS);
        chk("nos2_no_move", 64'(state), 64'(S_LF2));
        rx_word(1, W_NOS);
        chk("lf1_state", 64'(state), 64'(S_LF1));
        chk("lf1_tx", 64'(tx_data), 64'(W_OLS));
        repeat (3) rx_word(1, W_OLS);
        chk("ol2_state", 64'(state), 64'(S_OL2));
        chk("ol2_tx", 64'(tx_data), 64'(W_LR));
        chk("ol2_fail_cnt", 64'(link_fail_cnt), 64'd1);
        repeat (3) rx_word(1, W_LRR);
        chk("lr3_state", 64'(state), 64'(S_LR3));
        chk("lr3_tx", 64'(tx_data), 64'(W_IDLE));
        chk("lr3_link_up", 64'(link_up), 64'd0);
        rx_word(1, W_IDLE);
        chk("ac_state", 64'(state), 64'(S_AC));
        chk("ac_link_up", 64'(link_up), 64'd1);

        // 6-word frame, tx_ready gap before word 3
        frame[5] = 36'h8BC95D5D5;
        mon_en = 1'b1;
        repeat (2) @(posedge clk); #1;
        push_frame(6, 3);
        repeat (3) @(posedge clk); #1;
        mon_en = 1'b0;
        f = 0;
        while (f < txq.size() && txq[f] == W_IDLE) f++;
        chk("fr_idle_before", 64'(f > 0), 64'd1);
        chk("fr_len", 64'(txq.size() >= f + 7), 64'd1);
        for (int k = 0; k < 6; k++)
            if (f + k < txq.size()) chk($sformatf("fr_word_%0d", k), 64'(txq[f + k]), 64'(frame[k]));
        if (f + 6 < txq.size()) chk("fr_idle_after", 64'(txq[f + 6]), 64'(W_IDLE));
        chk("fr_no_drop", 64'(frm_drop_cnt), 64'd0);
        frame[5] = 36'h0D0000005;

        // near-miss sequences must not leave AC
        rx_word(1, W_NOS); rx_word(1, W_NOS); rx_word(1, W_IDLE);
        chk("near_nos_idle", 64'(state), 64'(S_AC));
        rx_word(1, W_NOS); rx_word(1, W_NOS); rx_word(1, W_OLS); rx_word(1, W_NOS);
        chk("near_nos_ols", 64'(state), 64'(S_AC));
        rx_word(1, W_IDLE);

        // 8-word frame, link recovery requested during word 3
        idx = 0;
        rx_valid = 1'b1; rx_data = W_LR;
        for (cyc = 0; cyc < 30 && idx < 8; cyc++) begin
            frm_data = frame[idx]; frm_valid = 1'b1;
            frm_sop = (idx == 0); frm_eop = (idx == 7);
            @(negedge clk); acc = frm_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        frm_valid = 1'b0; frm_sop = 1'b0; frm_eop = 1'b0;
        @(posedge clk); #1;
        chk("lr_drained_all", 64'(idx), 64'd8);
        chk("lr_state", 64'(state), 64'(S_LR2));
        chk("lr_tx", 64'(tx_data), 64'(W_LRR));
        chk("lr_drop_cnt", 64'(frm_drop_cnt), 64'd1);
        chk("lr_frm_ready", 64'(frm_ready), 64'd0);
        rx_word(1, W_IDLE);
        chk("lr2_to_ac", 64'(state), 64'(S_AC));

        // loss of sync
        repeat (LOS - 1) rx_word(0, '0);
        chk("los_minus1", 64'(state), 64'(S_AC));
        rx_word(1, W_IDLE);
        repeat (LOS) rx_word(0, '0);
        chk("los_state", 64'(state), 64'(S_LF2));
        chk("los_tx", 64'(tx_data), 64'(W_NOS));
        chk("los_fail_cnt", 64'(link_fail_cnt), 64'd2);
        chk("los_link_up", 64'(link_up), 64'd0);

        // OL2 timeout
        repeat (3) rx_word(1, W_OLS);
        chk("tmo_ol2", 64'(state), 64'(S_OL2));
        repeat (TMO - 10) rx_word(1, W_DATA);
        chk("tmo_early", 64'(state), 64'(S_OL2));
        repeat (15) rx_word(1, W_DATA);
        chk("tmo_state", 64'(state), 64'(S_LF2));
        chk("tmo_tx", 64'(tx_data), 64'(W_NOS));
        chk("tmo_fail_cnt", 64'(link_fail_cnt), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
